booth_mult_arbiter: RTL and testbench
=====================================

# booth_mult_arbiter

Shares one signed Booth multiplier datapath among `NUM_REQ` requesters. It arbitrates requests round-robin and registers the operands, then produces the full-precision product through a 2-stage pipeline. Results return on a single response channel tagged with the requester index, with valid/ready backpressure. The block sits between the multiplier and the client blocks that need multiplies.

## Interface
- `WIDTH`, 8, operand width; operands and product are two's complement.
- `NUM_REQ`, 4, number of requesters, 2..16.
- `ID_W`, `$clog2(NUM_REQ)`, response tag width (localparam).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  bit i: requester i has an operand pair.
- `req_ready`  out  NUM_REQ  bit i: requester i's pair is accepted this cycle (one-hot or zero).
- `req_a`  in  NUM_REQ*WIDTH  multiplicands; requester i at bits [i*WIDTH +: WIDTH].
- `req_b`  in  NUM_REQ*WIDTH  multipliers; same packing as `req_a`.
- `resp_valid`  out  1  response holds a product.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_product`  out  2*WIDTH  signed product a*b.
- `resp_id`  out  ID_W  index of the requester that issued the pair.
- `stat_grants`  out  NUM_REQ*16  per-requester grant counters; present only with `BOOTH_ARB_STATS_EN`.

## Operation
- **Pipeline:**
  - S1 is the operand register: `s1_valid`, `s1_a`, `s1_b`, `s1_id`.
  - The multiplier sits combinationally between S1 and S2.
  - S2 is the output register, which drives `resp_valid`, `resp_product` and `resp_id`.
- **Advance conditions:**
  - `s2_free = !resp_valid | resp_ready`.
  - `s1_free = !s1_valid | s2_free`.
  - S1 moves into S2 when `s1_valid & s2_free`.
  - When `s2_free` and `!s1_valid`, `resp_valid` falls to 0.
- **Arbitration:**
  - The round-robin pointer `rr_ptr` ranges 0..NUM_REQ-1.
  - Search order is `rr_ptr`, `rr_ptr+1`, …, wrapping at NUM_REQ. The first requester with `req_valid` set wins.
  - A grant happens only when `s1_free`.
  - `req_ready[i] = s1_free & winner==i`. This is combinational from `req_valid`, so requesters must not make `req_valid` depend on `req_ready`.
- **Pointer update:** on a handshake with requester i, `rr_ptr <= (i+1) mod NUM_REQ`. With no handshake, `rr_ptr` holds.
- **Arithmetic:**
  - `resp_product` is the exact signed WIDTH×WIDTH product; no truncation and no saturation.
  - For WIDTH=8 the extremes are: -128*-128 = 16384 (0x4000), -128*127 = -16256 (0xC080).
- **Stall:** while `resp_valid & !resp_ready`, `resp_product` and `resp_id` hold stable, and S1 holds. Once both stages are full, `req_ready` is 0.
- **Simultaneous events:** the S2 drain, the S1→S2 move and a new grant into S1 all occur in the same cycle when `resp_ready` is 1.
- **Reset:**
  - While `rst` is high, `req_ready` is forced to 0.
  - On the reset edge: `s1_valid`=0, `resp_valid`=0, `resp_product`=0, `resp_id`=0, `rr_ptr`=0, and all counters are 0.
  - Reset mid-operation discards in-flight pairs; no response is ever produced for them.

## Timing
- A request handshake in cycle T produces `resp_valid`=1 in cycle T+2 when there is no backpressure.
- Throughput is one product per cycle when `resp_ready` is held at 1.
- Capacity is 2 in-flight operations (S1 + S2).
- The multiplier path S1→S2 must close in one cycle at the target clock.
- `req_ready` has a combinational path from `req_valid`, `resp_valid` and `resp_ready`. There is no combinational path from `req_*` to `resp_*`.

## Configuration
- **Macro:** `BOOTH_ARB_STATS_EN`.
- **Defined:**
  - The `stat_grants` port exists.
  - Counter i increments on each handshake with requester i.
  - Counters saturate at 0xFFFF and do not wrap.
  - Counters clear only on `rst`.
- **Undefined:** the port and counters are absent, and all other behaviour is identical.

## Test plan
- **Reset values:** hold `rst` 3 cycles with all `req_valid`=1. Required: `req_ready`=0, `resp_valid`=0, `resp_product`=0, `resp_id`=0. First cycle after reset: `req_ready`=0001 (NUM_REQ=4).
- **Single op, WIDTH=8:** requester 2 sends a=-128, b=-128. Required: `resp_valid` two cycles later with `resp_product`=0x4000 and `resp_id`=2. Also check a=-128, b=127 gives 0xC080, and a=0, b=-1 gives 0.
- **Fairness:** all 4 requesters hold `req_valid` for 8 cycles with `resp_ready`=1. Required: grants in order 0,1,2,3,0,1,2,3, and the `resp_id` sequence matches 2 cycles later.
- **Backpressure:** `resp_ready`=0 for 5 cycles with continuous requests. Required: exactly 2 accepted, then `req_ready`=0; `resp_product` stable throughout. Releasing `resp_ready` gives both results in order, then resumed issue with no loss or duplication.
- **Mid-operation reset:** reset asserted in the cycle after a handshake. Required: no response appears after reset and `rr_ptr` restarts at 0.
- **Random check:** 10k random operand pairs with random `req_valid`/`resp_ready` compared against a behavioural signed a*b per id. With `BOOTH_ARB_STATS_EN`, counters equal the number of handshakes per requester.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin arbiter in front of a shared signed radix-4 Booth
// multiplier. S1 is the operand register and S2 the response register, so each
// response is tagged with the id of the requester that issued it.
// Optional feature: define BOOTH_ARB_STATS_EN to add saturating per-requester grant
// counters on the stat_grants port.
module booth_mult_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [2*WIDTH-1:0]         resp_product,
    output logic [ID_W-1:0]            resp_id
`ifdef BOOTH_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]      stat_grants
`endif
);

    localparam int unsigned PW = 2 * WIDTH;
    // Booth recoding needs an even multiplier width; odd widths get one extra sign bit.
    localparam int unsigned BW = WIDTH + (WIDTH % 2);
    localparam int unsigned ND = BW / 2;

    logic                     s1_valid;
    logic signed [WIDTH-1:0]  s1_a;
    logic signed [WIDTH-1:0]  s1_b;
    logic [ID_W-1:0]          s1_id;
    logic [ID_W-1:0]          rr_ptr;

    logic                     s2_free;
    logic                     s1_free;
    logic                     found;
    logic                     grant;
    logic [ID_W-1:0]          winner;
    logic signed [PW-1:0]     product;

    assign s2_free = !resp_valid || resp_ready;
    assign s1_free = !s1_valid || s2_free;
    assign grant   = !rst && s1_free && found;

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - int'(NUM_REQ);
            end
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // One-hot ready for the winner, only when S1 can take a new pair.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_ready[i] = grant && (winner == ID_W'(i));
        end
    end

    // Radix-4 Booth multiplier: one partial product per overlapping bit triplet of b.
    always_comb begin
        logic signed [PW-1:0] a_ext;
        logic signed [BW-1:0] b_se;
        logic [BW:0]          bx;
        logic signed [PW-1:0] pp;
        a_ext   = PW'(s1_a);
        b_se    = BW'(s1_b);
        bx      = {b_se, 1'b0};
        product = '0;
        for (int d = 0; d < int'(ND); d++) begin
            case (bx[2*d +: 3])
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext <<< 1;
                3'b100:         pp = -(a_ext <<< 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            product = product + (pp <<< (2 * d));
        end
    end

    // Pipeline state: S2 drain/load, S1 load on grant, round-robin pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_a         <= '0;
            s1_b         <= '0;
            s1_id        <= '0;
            resp_valid   <= 1'b0;
            resp_product <= '0;
            resp_id      <= '0;
            rr_ptr       <= '0;
        end else begin
            if (s2_free) begin
                resp_valid <= s1_valid;
                if (s1_valid) begin
                    resp_product <= product;
                    resp_id      <= s1_id;
                end
            end
            if (s1_free) begin
                s1_valid <= grant;
            end
            if (grant) begin
                s1_a   <= req_a[winner*WIDTH +: WIDTH];
                s1_b   <= req_b[winner*WIDTH +: WIDTH];
                s1_id  <= winner;
                rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

`ifdef BOOTH_ARB_STATS_EN
    // Saturating grant counters, one 16-bit field per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (req_ready[i] && stat_grants[i*16 +: 16] != 16'hFFFF) begin
                    stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter (WIDTH=8, NUM_REQ=4). Stimulus pushes the
// hand-computed product of every accepted pair; a monitor pops on each response.
module tb_booth_mult_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_product;
    logic [1:0]  resp_id;
`ifdef BOOTH_ARB_STATS_EN
    logic [63:0] stat_grants;
`endif

    booth_mult_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_product (resp_product),
        .resp_id      (resp_id)
`ifdef BOOTH_ARB_STATS_EN
        ,
        .stat_grants  (stat_grants)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        logic [1:0]  id;
    } sb_t;

    sb_t         sbq[$];
    int          grant_log[$];
    logic [15:0] cur_exp[4];
    int          hs_count[4];
    int          errors;
    int          checks;

    logic [3:0]  snap_ready;
    logic        snap_valid;
    logic [1:0]  snap_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: snapshot and log handshakes at the negedge, return 1ns after posedge.
    task automatic step();
        @(negedge clk);
        snap_ready = req_ready;
        snap_valid = resp_valid;
        snap_id    = resp_id;
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) begin
                sbq.push_back('{cur_exp[i], 2'(i)});
                grant_log.push_back(i);
                hs_count[i]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] p);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        cur_exp[i]      = p;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sbq.size() != 0; k++) step();
        check("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    // Single op on requester 2 with explicit two-cycle latency check.
    task automatic single_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        set_op(2, a, b, p);
        req_valid = 4'b0100;
        step();
        check("single_ready", 32'(snap_ready), 32'h4);
        req_valid = 4'b0000;
        step();
        check("single_lat_t1_valid", 32'(snap_valid), 32'd0);
        step();
        check("single_lat_t2_valid", 32'(snap_valid), 32'd1);
        check("single_lat_t2_id", 32'(snap_id), 32'd2);
    endtask

    // Monitor: pop on each accepted response; verify the output holds while stalled.
    logic        prev_stall;
    logic [15:0] prev_prod;
    logic [1:0]  prev_id;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(resp_valid), 32'd1);
                check("stall_product", 32'(resp_product), 32'(prev_prod));
                check("stall_id", 32'(resp_id), 32'(prev_id));
            end
            if (resp_valid && resp_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got id=%0d product=0x%0h, expected none",
                             resp_id, resp_product);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    check("resp_product", 32'(resp_product), 32'(e.prod));
                    check("resp_id", 32'(resp_id), 32'(e.id));
                end
            end
            prev_stall = resp_valid && !resp_ready;
            prev_prod  = resp_product;
            prev_id    = resp_id;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        int fair_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int bp_order[2]   = '{3, 0};
        int res_order[4]  = '{1, 2, 3, 0};
        errors = 0;
        checks = 0;
        for (int i = 0; i < 4; i++) hs_count[i] = 0;
        req_a = '0;
        req_b = '0;

        // Reset with all requesters asserting.
        set_op(0, 8'h80, 8'h7F, 16'hC080);  // -128*127
        set_op(1, 8'h7F, 8'h7F, 16'h3F01);  // 127*127
        set_op(2, 8'hF9, 8'h09, 16'hFFC1);  // -7*9
        set_op(3, 8'h0C, 8'h0D, 16'h009C);  // 12*13
        rst        = 1'b1;
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        step();
        check("rst_req_ready", 32'(snap_ready), 32'd0);
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_req_ready", 32'(snap_ready), 32'd0);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_resp_product", 32'(resp_product), 32'd0);
            check("rst_resp_id", 32'(resp_id), 32'd0);
        end
        rst = 1'b0;

        // Fairness: 8 cycles of all-valid from a fresh pointer.
        step();
        check("post_rst_ready", 32'(snap_ready), 32'h1);
        repeat (7) step();
        req_valid = 4'h0;
        check("fair_grants", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            check("fair_order", 32'(grant_log[k]), 32'(fair_order[k]));
        drain();

        // Single ops with extremes.
        single_op(8'h80, 8'h80, 16'h4000);  // -128*-128
        single_op(8'h80, 8'h7F, 16'hC080);  // -128*127
        single_op(8'h00, 8'hFF, 16'h0000);  // 0*-1
        single_op(8'h05, 8'hFD, 16'hFFF1);  // 5*-3
        drain();

        // Backpressure: only two pairs fit while the consumer stalls.
        set_op(0, 8'hFF, 8'hFF, 16'h0001);  // -1*-1
        set_op(1, 8'h05, 8'hFD, 16'hFFF1);  // 5*-3
        set_op(2, 8'h64, 8'hFE, 16'hFF38);  // 100*-2
        set_op(3, 8'h80, 8'h01, 16'hFF80);  // -128*1
        base       = grant_log.size();
        resp_ready = 1'b0;
        req_valid  = 4'hF;
        repeat (5) step();
        check("bp_accepted", 32'(grant_log.size() - base), 32'd2);
        check("bp_ready_zero", 32'(snap_ready), 32'd0);
        for (int k = 0; k < 2 && base + k < grant_log.size(); k++)
            check("bp_order", 32'(grant_log[base+k]), 32'(bp_order[k]));
        req_valid  = 4'h0;
        resp_ready = 1'b1;
        step();
        step();
        check("bp_released", 32'(sbq.size()), 32'd0);
        set_op(0, 8'h01, 8'h01, 16'h0001);  // 1*1
        set_op(1, 8'hFF, 8'h01, 16'hFFFF);  // -1*1
        set_op(2, 8'h00, 8'hFF, 16'h0000);  // 0*-1
        set_op(3, 8'h7F, 8'h80, 16'hC080);  // 127*-128
        base      = grant_log.size();
        req_valid = 4'hF;
        repeat (4) step();
        req_valid = 4'h0;
        check("resume_grants", 32'(grant_log.size() - base), 32'd4);
        for (int k = 0; k < 4 && base + k < grant_log.size(); k++)
            check("resume_order", 32'(grant_log[base+k]), 32'(res_order[k]));
        drain();

        // Reset right after a handshake discards the pair and restarts the pointer.
        set_op(2, 8'h03, 8'h04, 16'h000C);
        req_valid = 4'b0100;
        step();
        check("midrst_hs", 32'(snap_ready), 32'h4);
        req_valid = 4'h0;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
        sbq.delete();
        for (int i = 0; i < 4; i++) hs_count[i] = 0;
        repeat (4) begin
            step();
            check("midrst_no_resp", 32'(snap_valid), 32'd0);
        end
        set_op(0, 8'hF9, 8'h09, 16'hFFC1);
        req_valid = 4'hF;
        step();
        check("midrst_ptr_zero", 32'(snap_ready), 32'h1);
        req_valid = 4'h0;
        drain();

`ifdef BOOTH_ARB_STATS_EN
        for (int i = 0; i < 4; i++)
            check("stat_grants", 32'(stat_grants[i*16 +: 16]), 32'(hs_count[i]));
`endif
        check("sb_final_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
